// File: rtl/hack_data_memory_pkg.sv
// Address map and region decode for the Hack data-memory responder.
// Optional HACK_MEM_TIMER_EN adds a read-only cycle timer at TIMER_ADDR.
package hack_data_memory_pkg;

   localparam int          RAM_DEPTH    = 16384;
   localparam int          RAM_AW       = 14;
   localparam logic [15:0] SCREEN_BASE  = 16'h4000;
   localparam int          SCREEN_DEPTH = 8192;
   localparam int          SCR_AW       = 13;
   localparam logic [15:0] KBD_ADDR     = 16'h6000;
   localparam logic [15:0] TIMER_ADDR   = 16'h6001;

   localparam logic [2:0] REG_RAM  = 3'd0;
   localparam logic [2:0] REG_SCR  = 3'd1;
   localparam logic [2:0] REG_KBD  = 3'd2;
   localparam logic [2:0] REG_TMR  = 3'd3;
   localparam logic [2:0] REG_NONE = 3'd4;

   function automatic logic [2:0] decode_region(input logic [15:0] addr);
      logic [2:0] r;
      r = REG_NONE;
      if (addr < 16'(RAM_DEPTH))
         r = REG_RAM;
      else if (addr >= SCREEN_BASE && addr < SCREEN_BASE + 16'(SCREEN_DEPTH))
         r = REG_SCR;
      else if (addr == KBD_ADDR)
         r = REG_KBD;
`ifdef HACK_MEM_TIMER_EN
      else if (addr == TIMER_ADDR)
         r = REG_TMR;
`endif
      return r;
   endfunction

endpackage

// File: rtl/hack_data_memory_ram.sv
// Word RAM: one synchronous write port, one asynchronous read port and an
// optional registered second read port (old data on same-edge collision).
module hack_ram #(
   parameter int DEPTH    = 16384,
   parameter int AW       = 14,
   parameter bit PORT2_EN = 1'b0
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          we,
   input  logic [AW-1:0] waddr,
   input  logic [15:0]   wdata,
   input  logic [AW-1:0] raddr,
   output logic [15:0]   rdata,
   input  logic [AW-1:0] raddr2,
   output logic [15:0]   rdata2
);

   logic [15:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (we)
         mem[waddr] <= wdata;
   end

   assign rdata = mem[raddr];

   generate
      if (PORT2_EN) begin : g_port2
         always_ff @(posedge clk) begin
            if (!reset)
               rdata2 <= '0;
            else
               rdata2 <= mem[raddr2];
         end
      end else begin : g_no_port2
         logic unused_port2;
         assign rdata2       = '0;
         assign unused_port2 = &{1'b0, raddr2, reset};
      end
   endgenerate

endmodule

// File: rtl/hack_data_memory.sv
// Hack CPU data-memory responder: RAM, screen buffer, keyboard register,
// display scan port. Define HACK_MEM_TIMER_EN to add the cycle timer.
module hack_data_memory
   import hack_data_memory_pkg::*;
(
   input  logic        clk,
   input  logic        reset,
   input  logic [15:0] addressM,
   input  logic [15:0] outM,
   input  logic        writeM,
   output logic [15:0] inM,
   input  logic [15:0] kbd_code,
   input  logic        kbd_valid,
   input  logic [12:0] scr_addr,
   output logic [15:0] scr_data
);

   logic [2:0]  region;
   logic        ram_we;
   logic        scr_we;
   logic [15:0] ram_rdata;
   logic [15:0] scr_rdata;
   logic [15:0] unused_ram_rd2;
   logic [15:0] kbd_reg;

   assign region = decode_region(addressM);
   assign ram_we = writeM && reset && (region == REG_RAM);
   assign scr_we = writeM && reset && (region == REG_SCR);

   hack_ram #(.DEPTH(RAM_DEPTH), .AW(RAM_AW), .PORT2_EN(1'b0)) u_ram (
      .clk    (clk),
      .reset  (reset),
      .we     (ram_we),
      .waddr  (addressM[RAM_AW-1:0]),
      .wdata  (outM),
      .raddr  (addressM[RAM_AW-1:0]),
      .rdata  (ram_rdata),
      .raddr2 ('0),
      .rdata2 (unused_ram_rd2)
   );

   // SCREEN_BASE is aligned to SCREEN_DEPTH, so the low bits are the offset.
   hack_ram #(.DEPTH(SCREEN_DEPTH), .AW(SCR_AW), .PORT2_EN(1'b1)) u_screen (
      .clk    (clk),
      .reset  (reset),
      .we     (scr_we),
      .waddr  (addressM[SCR_AW-1:0]),
      .wdata  (outM),
      .raddr  (addressM[SCR_AW-1:0]),
      .rdata  (scr_rdata),
      .raddr2 (scr_addr),
      .rdata2 (scr_data)
   );

   always_ff @(posedge clk) begin
      if (!reset)
         kbd_reg <= '0;
      else if (kbd_valid)
         kbd_reg <= kbd_code;
   end

`ifdef HACK_MEM_TIMER_EN
   logic [15:0] timer;

   always_ff @(posedge clk) begin
      if (!reset)
         timer <= '0;
      else
         timer <= timer + 16'd1;
   end
`endif

   always_comb begin
      inM = 16'h0000;
      case (region)
         REG_RAM: inM = ram_rdata;
         REG_SCR: inM = scr_rdata;
         REG_KBD: inM = kbd_reg;
`ifdef HACK_MEM_TIMER_EN
         REG_TMR: inM = timer;
`endif
         default: inM = 16'h0000;
      endcase
   end

endmodule

// File: tb/tb_hack_data_memory.sv
// Self-checking bench for hack_data_memory: vector table, hand sequences,
// and randomized traffic against an address-map reference model.
module tb_hack_data_memory;

   logic        clk = 1'b0;
   logic        reset;
   logic [15:0] addressM;
   logic [15:0] outM;
   logic        writeM;
   logic [15:0] inM;
   logic [15:0] kbd_code;
   logic        kbd_valid;
   logic [12:0] scr_addr;
   logic [15:0] scr_data;

   int n_tests = 0;
   int n_fail  = 0;

   hack_data_memory dut (
      .clk       (clk),
      .reset     (reset),
      .addressM  (addressM),
      .outM      (outM),
      .writeM    (writeM),
      .inM       (inM),
      .kbd_code  (kbd_code),
      .kbd_valid (kbd_valid),
      .scr_addr  (scr_addr),
      .scr_data  (scr_data)
   );

   always #5 clk = ~clk;

   // reference model: only addresses the bench has written are "known"
   logic [15:0] ram_m [int];
   logic [15:0] scr_m [int];
   logic [15:0] kbd_m = 16'h0;
   logic [15:0] tmr_m = 16'h0;
   logic [15:0] scan_m = 16'h0;
   bit          scan_known = 1'b1;

   typedef struct {
      logic [15:0] addr;
      logic [15:0] wdata;
      logic        we;
      logic [15:0] kcode;
      logic        kvalid;
      logic [12:0] saddr;
      bit          chk_in;
      logic [15:0] exp_in;
      bit          chk_scr;
      logic [15:0] exp_scr;
   } vec_t;

   vec_t vecs[$];

   function automatic vec_t mk(input logic [15:0] a, input logic [15:0] d, input logic w,
                               input logic [15:0] kc, input logic kv, input logic [12:0] sa,
                               input bit ci, input logic [15:0] ei, input bit cs,
                               input logic [15:0] es);
      vec_t v;
      v.addr = a; v.wdata = d; v.we = w; v.kcode = kc; v.kvalid = kv; v.saddr = sa;
      v.chk_in = ci; v.exp_in = ei; v.chk_scr = cs; v.exp_scr = es;
      return v;
   endfunction

   task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Expected read for an address, purely from the memory-map rules.
   function automatic bit model_read(input int a, output logic [15:0] v);
      v = 16'h0;
      if (a < 16384) begin
         if (!ram_m.exists(a)) return 1'b0;
         v = ram_m[a];
      end else if (a >= 'h4000 && a < 'h6000) begin
         if (!scr_m.exists(a - 'h4000)) return 1'b0;
         v = scr_m[a - 'h4000];
      end else if (a == 'h6000) begin
         v = kbd_m;
      end else if (a == 'h6001) begin
`ifdef HACK_MEM_TIMER_EN
         v = tmr_m;
`else
         v = 16'h0;
`endif
      end
      return 1'b1;
   endfunction

   // Advance the model over one rising edge using the current inputs.
   task automatic model_edge();
      int a;
      a = int'(addressM);
      if (!reset) begin
         kbd_m = 16'h0;
         tmr_m = 16'h0;
         scan_m = 16'h0;
         scan_known = 1'b1;
      end else begin
         scan_known = scr_m.exists(int'(scr_addr));
         if (scan_known) scan_m = scr_m[int'(scr_addr)];
         if (kbd_valid) kbd_m = kbd_code;
         tmr_m = tmr_m + 16'd1;
         if (writeM) begin
            if (a < 16384) ram_m[a] = outM;
            else if (a >= 'h4000 && a < 'h6000) scr_m[a - 'h4000] = outM;
         end
      end
   endtask

   task automatic tick();
      model_edge();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic [15:0] a, input logic [15:0] d, input logic w,
                        input logic [15:0] kc, input logic kv, input logic [12:0] sa);
      addressM = a; outM = d; writeM = w; kbd_code = kc; kbd_valid = kv; scr_addr = sa;
   endtask

   task automatic check_inm_model(input string name);
      logic [15:0] e;
      #1;
      if (model_read(int'(addressM), e)) check(name, inM, e);
   endtask

   initial begin
      logic [15:0] e;
      logic [15:0] prior;
      drive(16'h0, 16'h0, 1'b0, 16'h0, 1'b0, 13'h0);
      reset = 1'b0;
      @(negedge clk);
      tick();
      reset = 1'b1;
      check("reset_scr_data", scr_data, 16'h0);
      addressM = 16'h6000; #1;
      check("reset_kbd", inM, 16'h0);

      //         addr      wdata     we    kcode  kv    saddr  ci  exp_in   cs  exp_scr
      vecs.push_back(mk(16'd1000, 16'd11110, 1'b1, 16'd0, 1'b0, 13'd0,  0, 16'h0,   0, 16'h0));
      vecs.push_back(mk(16'd1000, 16'h0,   1'b0, 16'd0, 1'b0, 13'd0,  1, 16'd11110, 0, 16'h0));
      vecs.push_back(mk(16'h4010, 16'hA5A5, 1'b1, 16'd0, 1'b0, 13'd0, 0, 16'h0,   0, 16'h0));
      vecs.push_back(mk(16'h4010, 16'h0,   1'b0, 16'd0, 1'b0, 13'd16, 1, 16'hA5A5, 1, 16'hA5A5));
      vecs.push_back(mk(16'h4010, 16'h5A5A, 1'b1, 16'd0, 1'b0, 13'd16, 1, 16'hA5A5, 1, 16'hA5A5));
      vecs.push_back(mk(16'h4010, 16'h0,   1'b0, 16'd0, 1'b0, 13'd16, 1, 16'h5A5A, 1, 16'h5A5A));
      vecs.push_back(mk(16'h6000, 16'h0,   1'b0, 16'd75, 1'b1, 13'd16, 1, 16'h0,   0, 16'h0));
      vecs.push_back(mk(16'h6000, 16'd9,   1'b1, 16'd0, 1'b0, 13'd16, 1, 16'd75,  0, 16'h0));
      vecs.push_back(mk(16'h6000, 16'd9,   1'b1, 16'd0, 1'b1, 13'd16, 1, 16'd75,  0, 16'h0));
      vecs.push_back(mk(16'h6000, 16'h0,   1'b0, 16'd0, 1'b0, 13'd16, 1, 16'h0,   0, 16'h0));
      vecs.push_back(mk(16'd2,    16'h0202, 1'b1, 16'd0, 1'b0, 13'd0, 0, 16'h0,   0, 16'h0));
      vecs.push_back(mk(16'h4002, 16'h0402, 1'b1, 16'd0, 1'b0, 13'd0, 0, 16'h0,   0, 16'h0));
      vecs.push_back(mk(16'h6002, 16'd123, 1'b1, 16'd0, 1'b0, 13'd0,  1, 16'h0,   0, 16'h0));
      vecs.push_back(mk(16'h8000, 16'd123, 1'b1, 16'd0, 1'b0, 13'd0,  1, 16'h0,   0, 16'h0));
      vecs.push_back(mk(16'h6002, 16'h0,   1'b0, 16'd0, 1'b0, 13'd0,  1, 16'h0,   0, 16'h0));
      vecs.push_back(mk(16'h8000, 16'h0,   1'b0, 16'd0, 1'b0, 13'd0,  1, 16'h0,   0, 16'h0));
      vecs.push_back(mk(16'd2,    16'h0,   1'b0, 16'd0, 1'b0, 13'd2,  1, 16'h0202, 1, 16'h0402));
      vecs.push_back(mk(16'h4002, 16'h0,   1'b0, 16'd0, 1'b0, 13'd2,  1, 16'h0402, 1, 16'h0402));
      vecs.push_back(mk(16'h3FFF, 16'h1111, 1'b1, 16'd0, 1'b0, 13'd0, 0, 16'h0,   0, 16'h0));
      vecs.push_back(mk(16'h5FFF, 16'h2222, 1'b1, 16'd0, 1'b0, 13'd0, 0, 16'h0,   0, 16'h0));
      vecs.push_back(mk(16'h3FFF, 16'h0,   1'b0, 16'd0, 1'b0, 13'd8191, 1, 16'h1111, 1, 16'h2222));
      vecs.push_back(mk(16'h5FFF, 16'h0,   1'b0, 16'd0, 1'b0, 13'd0,  1, 16'h2222, 0, 16'h0));
      vecs.push_back(mk(16'd0,    16'hAAAA, 1'b1, 16'd0, 1'b0, 13'd0, 0, 16'h0,   0, 16'h0));
      vecs.push_back(mk(16'h4000, 16'hBBBB, 1'b1, 16'd0, 1'b0, 13'd0, 0, 16'h0,   0, 16'h0));
      vecs.push_back(mk(16'd0,    16'h0,   1'b0, 16'd0, 1'b0, 13'd0,  1, 16'hAAAA, 1, 16'hBBBB));
      vecs.push_back(mk(16'h4000, 16'h0,   1'b0, 16'd0, 1'b0, 13'd0,  1, 16'hBBBB, 0, 16'h0));
      vecs.push_back(mk(16'd5,    16'h0505, 1'b1, 16'd75, 1'b1, 13'd0, 0, 16'h0,  0, 16'h0));

      for (int i = 0; i < vecs.size(); i++) begin
         drive(vecs[i].addr, vecs[i].wdata, vecs[i].we, vecs[i].kcode, vecs[i].kvalid, vecs[i].saddr);
         #1;
         if (vecs[i].chk_in) check($sformatf("vec%0d_inM", i), inM, vecs[i].exp_in);
         tick();
         if (vecs[i].chk_scr) check($sformatf("vec%0d_scr", i), scr_data, vecs[i].exp_scr);
      end

      // RAM 1001 holds whatever it held; a write elsewhere must not change it
      drive(16'd1001, 16'h0, 1'b0, 16'h0, 1'b0, 13'd0); #1;
      prior = inM;
      drive(16'd1000, 16'h7777, 1'b1, 16'h0, 1'b0, 13'd0);
      tick();
      drive(16'd1001, 16'h0, 1'b0, 16'h0, 1'b0, 13'd0); #1;
      check("ram1001_unchanged", inM, prior);

      // reset mid-write: RAM[5] keeps 0x0505, kbd and scan clear
      drive(16'd5, 16'd77, 1'b1, 16'h0, 1'b0, 13'd16);
      reset = 1'b0;
      tick();
      reset = 1'b1;
      check("rst_scr_data", scr_data, 16'h0);
      drive(16'd5, 16'h0, 1'b0, 16'h0, 1'b0, 13'd16); #1;
      check("rst_ram5_kept", inM, 16'h0505);
      addressM = 16'h6000; #1;
      check("rst_kbd_clear", inM, 16'h0);
      addressM = 16'h6001; #1;
      if (model_read(int'(addressM), e)) check("timer_addr_read", inM, e);

      // randomized traffic
      for (int i = 0; i < 400; i++) begin
         logic [15:0] a;
         case ($urandom_range(0, 6))
            0, 1: a = 16'($urandom_range(0, 31));
            2:    a = 16'h3FE0 + 16'($urandom_range(0, 31));
            3:    a = 16'h4000 + 16'($urandom_range(0, 31));
            4:    a = 16'h5FE0 + 16'($urandom_range(0, 31));
            5:    a = 16'h6000 + 16'($urandom_range(0, 1));
            default: a = 16'($urandom_range(16'h6002, 16'hFFFF));
         endcase
         drive(a, 16'($urandom), 1'($urandom_range(0, 1)), 16'($urandom),
               ($urandom_range(0, 7) == 0), 13'($urandom_range(0, 31)));
         check_inm_model($sformatf("rnd%0d_inM", i));
         tick();
         if (scan_known) check($sformatf("rnd%0d_scr", i), scr_data, scan_m);
      end

`ifdef HACK_MEM_TIMER_EN
      drive(16'h6001, 16'h0, 1'b0, 16'h0, 1'b0, 13'd0);
      reset = 1'b0;
      tick();
      reset = 1'b1;
      repeat (10) tick();
      check("timer_10", inM, 16'd10);
      repeat (65526) tick();
      check("timer_wrap", inM, 16'd0);
`endif

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
